// File: rtl/digit_counter_gen.sv
// Single timer digit: up/down counter with runtime limit, load/clear,
// ripple carry out for cascading, and a blinkable 7-segment encoder.
module digit_counter_gen #(
  parameter int unsigned MAX_VAL        = 9,
  parameter int unsigned RESET_VAL      = 0,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       timer_clk,
  input  logic       int_reset_b,
  input  logic       cnt_en,
  input  logic       cnt_dir,
  input  logic [3:0] limit,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  input  logic       blink_en,
  input  logic       blink_tick,
  output logic [3:0] digit_val,
  output logic [6:0] seg_out,
  output logic       tc_out,
  output logic       wrap_pulse
);

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 7;
  localparam logic [DW-1:0] MAX_L   = DW'(MAX_VAL);
  localparam logic [DW-1:0] RST_L   = DW'(RESET_VAL);
  localparam logic [SW-1:0] SEG_OFF = SEG_ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};

  typedef enum logic {VIS = 1'b0, BLANK = 1'b1} blink_t;

  // Hex digit to {a..g}, polarity applied at the end
  function automatic logic [SW-1:0] enc(input logic [DW-1:0] v);
    logic [SW-1:0] s;
    case (v)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  localparam logic [SW-1:0] SEG_RST = enc(RST_L);

  logic [DW-1:0] eff_lim;
  logic          at_term;
  logic [DW-1:0] digit_nxt;
  logic          wrap_nxt;
  logic [SW-1:0] seg_nxt;
  blink_t        blink_q;
  blink_t        blink_nxt;

  // Effective terminal value and terminal detection for the current direction
  always_comb begin
    eff_lim = (limit < MAX_L) ? limit : MAX_L;
    at_term = cnt_dir ? (digit_val >= eff_lim) : (digit_val == '0);
  end

  assign tc_out = cnt_en & ~clear & ~load & at_term;

  // Next digit value: clear > load > count > hold
  always_comb begin
    digit_nxt = digit_val;
    wrap_nxt  = 1'b0;
    if (clear) begin
      digit_nxt = '0;
    end else if (load) begin
      digit_nxt = (load_val < eff_lim) ? load_val : eff_lim;
    end else if (cnt_en) begin
      if (cnt_dir) begin
        if (at_term) begin
          digit_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          digit_nxt = digit_val + DW'(1);
        end
      end else begin
        if (at_term) begin
          digit_nxt = eff_lim;
          wrap_nxt  = 1'b1;
        end else if (digit_val > eff_lim) begin
          digit_nxt = eff_lim;
        end else begin
          digit_nxt = digit_val - DW'(1);
        end
      end
    end
  end

  // Blink phase register
  always_ff @(posedge timer_clk or negedge int_reset_b) begin
    if (!int_reset_b) blink_q <= VIS;
    else              blink_q <= blink_nxt;
  end

  // Blink next state; a load or clear forces the digit visible
  always_comb begin
    blink_nxt = blink_q;
    if (!blink_en || load || clear) begin
      blink_nxt = VIS;
    end else if (blink_tick) begin
      blink_nxt = (blink_q == VIS) ? BLANK : VIS;
    end
  end

  // Segment pattern for the upcoming edge, aligned with the new digit value
  always_comb begin
    seg_nxt = enc(digit_nxt);
    if (blink_nxt == BLANK) seg_nxt = SEG_OFF;
  end

  // Digit, segment and wrap registers
  always_ff @(posedge timer_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      digit_val  <= RST_L;
      seg_out    <= SEG_RST;
      wrap_pulse <= 1'b0;
    end else begin
      digit_val  <= digit_nxt;
      seg_out    <= seg_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_digit_counter_gen.sv
// Two chained digits (LSD -> MSD) against an arithmetic reference model.
module tb_digit_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b1, ben = 1'b0, btick = 1'b0;
  logic       ld0 = 1'b0, clr0 = 1'b0, ld1 = 1'b0, clr1 = 1'b0;
  logic [3:0] lim0 = 4'd9, lim1 = 4'd9, lv0 = 4'd0, lv1 = 4'd0;
  logic [3:0] d0, d1;
  logic [6:0] s0, s1;
  logic       tc0, tc1, w0, w1;

  int checks = 0;
  int errors = 0;

  int m_d [2];
  bit m_w [2];
  bit m_blank;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  digit_counter_gen u_lsd (
    .timer_clk(clk), .int_reset_b(rst_n), .cnt_en(en), .cnt_dir(dir),
    .limit(lim0), .load(ld0), .load_val(lv0), .clear(clr0),
    .blink_en(ben), .blink_tick(btick),
    .digit_val(d0), .seg_out(s0), .tc_out(tc0), .wrap_pulse(w0)
  );

  digit_counter_gen u_msd (
    .timer_clk(clk), .int_reset_b(rst_n), .cnt_en(tc0), .cnt_dir(dir),
    .limit(lim1), .load(ld1), .load_val(lv1), .clear(clr1),
    .blink_en(1'b0), .blink_tick(1'b0),
    .digit_val(d1), .seg_out(s1), .tc_out(tc1), .wrap_pulse(w1)
  );

  function automatic int eff(input logic [3:0] l);
    return (int'(l) < 9) ? int'(l) : 9;
  endfunction

  function automatic bit tc_m(input int d, input bit e_n, input bit c, input bit l,
                              input bit dr, input int e);
    return e_n && !c && !l && (dr ? (d >= e) : (d == 0));
  endfunction

  function automatic logic [6:0] seg_m(input int d, input bit blank);
    return blank ? 7'h7F : ~seg_tab[d];
  endfunction

  function automatic void nxt(input int d, input bit e_n, input bit dr, input int e,
                              input bit l, input int lv, input bit c,
                              output int nd, output bit w);
    nd = d;
    w  = 1'b0;
    if (c) nd = 0;
    else if (l) nd = (lv < e) ? lv : e;
    else if (e_n) begin
      if (dr) begin
        if (d >= e) begin nd = 0; w = 1'b1; end
        else nd = d + 1;
      end else begin
        if (d == 0) begin nd = e; w = 1'b1; end
        else if (d > e) nd = e;
        else nd = d - 1;
      end
    end
  endfunction

  task automatic model_reset();
    m_d[0] = 0; m_d[1] = 0; m_w[0] = 1'b0; m_w[1] = 1'b0; m_blank = 1'b0;
  endtask

  // Advance the model with the current inputs, then one clock edge
  task automatic step();
    int e0, e1, n0, n1;
    bit t0, x0, x1, nb;
    e0 = eff(lim0);
    e1 = eff(lim1);
    t0 = tc_m(m_d[0], en, clr0, ld0, dir, e0);
    nxt(m_d[0], en, dir, e0, ld0, int'(lv0), clr0, n0, x0);
    nxt(m_d[1], t0, dir, e1, ld1, int'(lv1), clr1, n1, x1);
    if (!ben || ld0 || clr0) nb = 1'b0;
    else if (btick) nb = !m_blank;
    else nb = m_blank;
    @(posedge clk);
    #1;
    m_d[0] = n0; m_d[1] = n1; m_w[0] = x0; m_w[1] = x1; m_blank = nb;
  endtask

  task automatic idle_inputs();
    en = 1'b0; ld0 = 1'b0; clr0 = 1'b0; ld1 = 1'b0; clr1 = 1'b0;
    ben = 1'b0; btick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (d0 !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d exp 0", d0); end
    checks++; if (s0 !== 7'h01) begin errors++; $display("FAIL reset_seg: got %h exp 01", s0); end
    checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b exp 0", w0); end
    checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b exp 0", tc0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up_count();
    lim0 = 4'd15; lim1 = 4'd15; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (tc0 !== (i == 9)) begin errors++; $display("FAIL up_tc[%0d]: got %b exp %b", i, tc0, (i == 9)); end
      step();
      checks++; if (d0 !== 4'((i + 1) % 10)) begin errors++; $display("FAIL up_digit[%0d]: got %0d exp %0d", i, d0, (i + 1) % 10); end
      checks++; if (s0 !== seg_m((i + 1) % 10, 1'b0)) begin errors++; $display("FAIL up_seg[%0d]: got %h exp %h", i, s0, seg_m((i + 1) % 10, 1'b0)); end
      checks++; if (w0 !== (i == 9)) begin errors++; $display("FAIL up_wrap[%0d]: got %b exp %b", i, w0, (i == 9)); end
    end
    en = 1'b0;
    step();
    checks++; if (w0 !== 1'b0) begin errors++; $display("FAIL up_wrap_one_cycle: got %b exp 0", w0); end
    checks++; if (d1 !== 4'(m_d[1])) begin errors++; $display("FAIL up_msd: got %0d exp %0d", d1, m_d[1]); end
  endtask

  task automatic test_chain();
    lim0 = 4'd9; lim1 = 4'd5;
    ld0 = 1'b1; lv0 = 4'd9; ld1 = 1'b1; lv1 = 4'd5;
    step();
    ld0 = 1'b0; ld1 = 1'b0;
    checks++; if ({d1, d0} !== 8'h59) begin errors++; $display("FAIL chain_load: got %h exp 59", {d1, d0}); end
    en = 1'b1; dir = 1'b1;
    #1;
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL chain_up_tc: got %b exp 1", tc1); end
    step();
    checks++; if ({d1, d0} !== 8'h00) begin errors++; $display("FAIL chain_up: got %h exp 00", {d1, d0}); end
    checks++; if ({w1, w0} !== 2'b11) begin errors++; $display("FAIL chain_up_wrap: got %b exp 11", {w1, w0}); end
    dir = 1'b0;
    #1;
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL chain_dn_tc: got %b exp 1", tc1); end
    step();
    checks++; if ({d1, d0} !== 8'h59) begin errors++; $display("FAIL chain_dn: got %h exp 59", {d1, d0}); end
    checks++; if ({w1, w0} !== 2'b11) begin errors++; $display("FAIL chain_dn_wrap: got %b exp 11", {w1, w0}); end
    checks++; if (s1 !== seg_m(5, 1'b0)) begin errors++; $display("FAIL chain_msd_seg: got %h exp %h", s1, seg_m(5, 1'b0)); end
    en = 1'b0; dir = 1'b1;
  endtask

  task automatic test_limit();
    lim0 = 4'd15; ld0 = 1'b1; lv0 = 4'd7;
    step();
    ld0 = 1'b0; lim0 = 4'd3;
    step();
    checks++; if (d0 !== 4'd7) begin errors++; $display("FAIL lim_hold: got %0d exp 7", d0); end
    en = 1'b1; dir = 1'b1;
    step();
    checks++; if (d0 !== 4'd0 || w0 !== 1'b1) begin errors++; $display("FAIL lim_up: got %0d/%b exp 0/1", d0, w0); end
    en = 1'b0; lim0 = 4'd15; ld0 = 1'b1; lv0 = 4'd7;
    step();
    ld0 = 1'b0; lim0 = 4'd3; en = 1'b1; dir = 1'b0;
    step();
    checks++; if (d0 !== 4'd3 || w0 !== 1'b0) begin errors++; $display("FAIL lim_dn: got %0d/%b exp 3/0", d0, w0); end
    en = 1'b0; ld0 = 1'b1; lv0 = 4'd12;
    step();
    ld0 = 1'b0;
    checks++; if (d0 !== 4'd3) begin errors++; $display("FAIL lim_load: got %0d exp 3", d0); end
    dir = 1'b1; lim0 = 4'd9;
  endtask

  task automatic test_priority();
    clr0 = 1'b1; ld0 = 1'b1; lv0 = 4'd5; en = 1'b1; dir = 1'b1;
    #1;
    checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL prio_tc: got %b exp 0", tc0); end
    step();
    checks++; if (d0 !== 4'd0 || w0 !== 1'b0) begin errors++; $display("FAIL prio_clear: got %0d/%b exp 0/0", d0, w0); end
    clr0 = 1'b0; lv0 = 4'd4;
    step();
    checks++; if (d0 !== 4'd4) begin errors++; $display("FAIL prio_load: got %0d exp 4", d0); end
    idle_inputs();
  endtask

  task automatic test_blink();
    bit loaded;
    loaded = 1'b0;
    lim0 = 4'd9; en = 1'b1; dir = 1'b1; ben = 1'b1;
    for (int c = 0; c < 24; c++) begin
      btick = (c % 4 == 0);
      ld0 = 1'b0;
      if (m_blank && !loaded && c > 8) begin
        ld0 = 1'b1; lv0 = 4'd6; loaded = 1'b1;
        step();
        checks++; if (s0 !== 7'h20 || d0 !== 4'd6) begin errors++; $display("FAIL blink_load: got %h/%0d exp 20/6", s0, d0); end
      end else begin
        step();
      end
      checks++; if (s0 !== seg_m(m_d[0], m_blank)) begin errors++; $display("FAIL blink_seg[%0d]: got %h exp %h", c, s0, seg_m(m_d[0], m_blank)); end
      checks++; if (d0 !== 4'(m_d[0])) begin errors++; $display("FAIL blink_digit[%0d]: got %0d exp %0d", c, d0, m_d[0]); end
    end
    ld0 = 1'b0; btick = 1'b0;
    if (!m_blank) begin
      btick = 1'b1;
      step();
      btick = 1'b0;
    end
    checks++; if (s0 !== 7'h7F) begin errors++; $display("FAIL blink_blank: got %h exp 7f", s0); end
    ben = 1'b0;
    step();
    checks++; if (s0 !== ~seg_tab[m_d[0]]) begin errors++; $display("FAIL blink_off: got %h exp %h", s0, ~seg_tab[m_d[0]]); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom);
      lim0  = 4'($urandom);
      lim1  = 4'($urandom);
      ld0   = ($urandom_range(0, 9) == 0);
      ld1   = ($urandom_range(0, 9) == 0);
      clr0  = ($urandom_range(0, 15) == 0);
      clr1  = ($urandom_range(0, 15) == 0);
      lv0   = 4'($urandom);
      lv1   = 4'($urandom);
      ben   = ($urandom_range(0, 3) != 0);
      btick = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (tc0 !== tc_m(m_d[0], en, clr0, ld0, dir, eff(lim0))) begin errors++; $display("FAIL rnd_tc0[%0d]: got %b", i, tc0); end
      checks++; if (tc1 !== tc_m(m_d[1], tc_m(m_d[0], en, clr0, ld0, dir, eff(lim0)), clr1, ld1, dir, eff(lim1))) begin errors++; $display("FAIL rnd_tc1[%0d]: got %b", i, tc1); end
      step();
      checks++; if (d0 !== 4'(m_d[0])) begin errors++; $display("FAIL rnd_d0[%0d]: got %0d exp %0d", i, d0, m_d[0]); end
      checks++; if (d1 !== 4'(m_d[1])) begin errors++; $display("FAIL rnd_d1[%0d]: got %0d exp %0d", i, d1, m_d[1]); end
      checks++; if (s0 !== seg_m(m_d[0], m_blank)) begin errors++; $display("FAIL rnd_s0[%0d]: got %h exp %h", i, s0, seg_m(m_d[0], m_blank)); end
      checks++; if (s1 !== seg_m(m_d[1], 1'b0)) begin errors++; $display("FAIL rnd_s1[%0d]: got %h exp %h", i, s1, seg_m(m_d[1], 1'b0)); end
      checks++; if ({w1, w0} !== {m_w[1], m_w[0]}) begin errors++; $display("FAIL rnd_wrap[%0d]: got %b%b exp %b%b", i, w1, w0, m_w[1], m_w[0]); end
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        checks++; if ({d1, d0} !== 8'h00 || s0 !== 7'h01 || w0 !== 1'b0) begin errors++; $display("FAIL rnd_midreset[%0d]: got %h/%h/%b exp 00/01/0", i, {d1, d0}, s0, w0); end
        model_reset();
        #2;
        rst_n = 1'b1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_chain();
    test_limit();
    test_priority();
    test_blink();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
